parity_ecc_stream_checker: RTL and testbench

PARITY_ECC_STREAM_CHECKER -- requirements
Module: parity_ecc_stream_checker

---
 rtl/parity_ecc_stream_checker_pkg.sv | 13 +
 rtl/parity_ecc_fifo2.sv | 54 +++++
 rtl/parity_ecc_stream_checker.sv | 100 ++++++++++
 tb/tb_parity_ecc_stream_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/parity_ecc_stream_checker_pkg.sv
// Shared definitions for the parity stream checker: alarm FSM encoding and
// codeword layout constants.
package parity_ecc_stream_checker_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } alarm_state_e;

  // Parity bit sits in the LSB; payload occupies the bits above it.
  localparam int PARITY_BIT = 0;

endpackage

// File: rtl/parity_ecc_fifo2.sv
// Generic 2-entry valid/ready FIFO. Ready depends on registered occupancy only,
// and the head entry is held stable until it is popped.
module parity_ecc_fifo2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             push;
  logic             pop;

  assign s_ready = (count_reg < 2'd2);
  assign m_valid = (count_reg != 2'd0);
  assign m_data  = mem_reg[rd_ptr_reg];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Storage is cleared on reset so nothing stale is ever presented on m_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= s_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/parity_ecc_stream_checker.sv
// Even-parity stream checker: tags each accepted codeword with a parity error
// flag, buffers it in a 2-entry FIFO and tracks a saturating error count/alarm.
module parity_ecc_stream_checker
  import parity_ecc_stream_checker_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CNT_WIDTH     = 16,
  parameter bit DROP_ON_ERROR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH:0]   s_codeword,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_error,
  input  logic [CNT_WIDTH-1:0]  err_threshold,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  alarm
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  parity_err;
  logic                  accept;
  logic                  fifo_in_valid;
  logic [DATA_WIDTH:0]   fifo_out;
  logic [CNT_WIDTH-1:0]  err_count_reg;
  logic [CNT_WIDTH-1:0]  err_count_next;
  alarm_state_e          state_reg;
  alarm_state_e          state_next;

  assign parity_err = s_codeword[PARITY_BIT] != (^s_codeword[DATA_WIDTH:1]);
  assign accept     = s_valid && s_ready;

  // Dropped words are still accepted (and counted); they just never reach the FIFO.
  assign fifo_in_valid = s_valid && !(DROP_ON_ERROR && parity_err);

  parity_ecc_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (fifo_in_valid),
    .s_ready (s_ready),
    .s_data  ({s_codeword[DATA_WIDTH:1], parity_err}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (fifo_out)
  );

  assign m_data  = fifo_out[DATA_WIDTH:1];
  assign m_error = fifo_out[0];

  always_comb begin
    err_count_next = err_count_reg;
    if (clear) begin
      err_count_next = '0;
    end else if (accept && parity_err && (err_count_reg != CNT_MAX)) begin
      err_count_next = err_count_reg + CNT_ONE;
    end
  end

  // Threshold is compared against the post-update count so the alarm rises
  // on the same edge that the count reaches the threshold.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NORMAL: begin
        if (!clear && (err_threshold != '0) && (err_count_next >= err_threshold)) begin
          state_next = ALARM;
        end
      end
      ALARM: begin
        if (clear) begin
          state_next = NORMAL;
        end
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
      state_reg     <= NORMAL;
    end else begin
      err_count_reg <= err_count_next;
      state_reg     <= state_next;
    end
  end

  assign err_count = err_count_reg;
  assign alarm     = (state_reg == ALARM);

endmodule

// File: tb/tb_parity_ecc_stream_checker.sv
// Directed bench for parity_ecc_stream_checker: default, drop-on-error and
// narrow-counter instances; inputs change and outputs are sampled on negedge.
module tb_parity_ecc_stream_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instances a (default) and d (DROP_ON_ERROR=1) share one stimulus.
  logic        a_s_valid, a_m_ready, a_clear;
  logic [8:0]  a_cw;
  logic [15:0] a_thr;
  logic        a_s_ready, a_m_valid, a_m_error, a_alarm;
  logic [7:0]  a_m_data;
  logic [15:0] a_err_count;
  logic        d_s_ready, d_m_valid, d_m_error, d_alarm;
  logic [7:0]  d_m_data;
  logic [15:0] d_err_count;

  logic        c_s_valid, c_m_ready, c_clear;
  logic [8:0]  c_cw;
  logic [1:0]  c_thr;
  logic        c_s_ready, c_m_valid, c_m_error, c_alarm;
  logic [7:0]  c_m_data;
  logic [1:0]  c_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  parity_ecc_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16), .DROP_ON_ERROR(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_codeword(a_cw),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_error(a_m_error),
    .err_threshold(a_thr), .clear(a_clear), .err_count(a_err_count), .alarm(a_alarm)
  );

  parity_ecc_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16), .DROP_ON_ERROR(1'b1)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .s_valid(a_s_valid), .s_ready(d_s_ready), .s_codeword(a_cw),
    .m_valid(d_m_valid), .m_ready(a_m_ready), .m_data(d_m_data), .m_error(d_m_error),
    .err_threshold(a_thr), .clear(a_clear), .err_count(d_err_count), .alarm(d_alarm)
  );

  parity_ecc_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2), .DROP_ON_ERROR(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_codeword(c_cw),
    .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .m_error(c_m_error),
    .err_threshold(c_thr), .clear(c_clear), .err_count(c_err_count), .alarm(c_alarm)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int exp_cnt[4]   = '{1, 2, 3, 3};
  int exp_alarm[4] = '{0, 1, 1, 1};

  initial begin
    rst_n = 1'b0;
    a_s_valid = 1'b0; a_m_ready = 1'b0; a_clear = 1'b0; a_cw = '0; a_thr = '0;
    c_s_valid = 1'b0; c_m_ready = 1'b1; c_clear = 1'b0; c_cw = '0; c_thr = 2'd2;
    step(); step();

    // Reset state
    check("rst_m_valid",   a_m_valid, 0);
    check("rst_s_ready",   a_s_ready, 1);
    check("rst_m_data",    a_m_data, 0);
    check("rst_m_error",   a_m_error, 0);
    check("rst_err_count", a_err_count, 0);
    check("rst_alarm",     c_alarm, 0);
    rst_n = 1'b1;
    step();

    // Clean codeword, 1-cycle latency
    a_s_valid = 1'b1; a_cw = 9'h14A; a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b0;
    check("clean_m_valid", a_m_valid, 1);
    check("clean_m_data",  a_m_data, 8'hA5);
    check("clean_m_error", a_m_error, 0);
    check("clean_cnt",     a_err_count, 0);
    step();
    check("clean_drained", a_m_valid, 0);

    // Errored codeword: forwarded by a, dropped by d
    a_s_valid = 1'b1; a_cw = 9'h14B;
    step();
    a_s_valid = 1'b0;
    check("err_m_data",    a_m_data, 8'hA5);
    check("err_m_error",   a_m_error, 1);
    check("err_cnt",       a_err_count, 1);
    check("drop_m_valid",  d_m_valid, 0);
    check("drop_cnt",      d_err_count, 1);
    step();

    // Backpressure: 0x01 (err), 0x02 (err), 0x03 (clean)
    a_m_ready = 1'b0; a_s_valid = 1'b1; a_cw = 9'h002;
    step();
    check("bp_ready_1", a_s_ready, 1);
    a_cw = 9'h004;
    step();
    check("bp_ready_full", a_s_ready, 0);
    check("bp_head_data",  a_m_data, 8'h01);
    check("bp_head_err",   a_m_error, 1);
    a_cw = 9'h006;
    step();
    check("bp_hold_ready", a_s_ready, 0);
    check("bp_hold_data",  a_m_data, 8'h01);
    a_m_ready = 1'b1;
    step();
    check("bp_out2_data",  a_m_data, 8'h02);
    check("bp_out2_err",   a_m_error, 1);
    step();
    a_s_valid = 1'b0;
    check("bp_out3_valid", a_m_valid, 1);
    check("bp_out3_data",  a_m_data, 8'h03);
    check("bp_out3_err",   a_m_error, 0);
    step();
    check("bp_empty",      a_m_valid, 0);
    check("bp_cnt",        a_err_count, 3);

    // Narrow counter saturation and alarm at threshold 2
    c_s_valid = 1'b1; c_cw = 9'h14B;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("sat_cnt_%0d", i),   c_err_count, exp_cnt[i]);
      check($sformatf("sat_alarm_%0d", i), c_alarm, exp_alarm[i]);
    end
    c_s_valid = 1'b0; c_clear = 1'b1;
    step();
    c_clear = 1'b0;
    check("clr_cnt",   c_err_count, 0);
    check("clr_alarm", c_alarm, 0);

    // Clear wins over a simultaneous errored accept; the word still flows
    c_s_valid = 1'b1;
    step();
    check("pre_clr_cnt", c_err_count, 1);
    c_clear = 1'b1;
    step();
    c_clear = 1'b0; c_s_valid = 1'b0;
    check("clr_err_cnt",     c_err_count, 0);
    check("clr_err_alarm",   c_alarm, 0);
    check("clr_err_m_valid", c_m_valid, 1);
    check("clr_err_m_error", c_m_error, 1);

    // Threshold 0 disables the alarm
    c_thr = 2'd0; c_s_valid = 1'b1;
    step(); step();
    c_s_valid = 1'b0;
    check("thr0_cnt",   c_err_count, 2);
    check("thr0_alarm", c_alarm, 0);

    // Mid-stream reset with two buffered words
    a_m_ready = 1'b0; a_s_valid = 1'b1; a_cw = 9'h14A;
    step(); step();
    a_s_valid = 1'b0;
    check("mid_full_valid", a_m_valid, 1);
    check("mid_full_ready", a_s_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", a_m_valid, 0);
    check("mid_rst_ready", a_s_ready, 1);
    check("mid_rst_cnt",   a_err_count, 0);
    check("mid_rst_c_cnt", c_err_count, 0);
    step();
    rst_n = 1'b1; a_m_ready = 1'b1;
    step();
    check("post_rst_valid_1", a_m_valid, 0);
    step();
    check("post_rst_valid_2", a_m_valid, 0);
    check("post_rst_data",    a_m_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
